instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 75 +++++++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the instruction fetch unit and its prefetch buffer:
//   instruction/address width, PC increment, fetch FSM state type and the
//   buffer entry layout (instruction word plus the address it was fetched from).
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    localparam int                 INSTR_W    = 32;
    localparam logic [INSTR_W-1:0] PC_INC     = 32'd4;
    localparam logic [INSTR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // FETCH   : no request outstanding
    // WAIT    : one request outstanding, its data is wanted
    // DISCARD : one request outstanding, but it belongs to a flushed stream
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Prefetch buffer for the instruction fetch unit. Stores {addr, instr}
//   entries; head is presented combinationally and only changes on pop.
//
// Ports
//   clk_i, reset_i  clock, asynchronous active-high reset
//   flush           synchronous empty (wins over push/pop)
//   push/push_entry write an entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            entry at the buffer head (meaningless when empty)
//   full/empty      occupancy flags
//   count           number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by count,
    // so the array can map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Sequential instruction prefetcher: issues word-aligned fetches with at
//   most one outstanding request, buffers returned words with their address,
//   and hands them to decode over a valid/ready handshake. A redirect flushes
//   the buffer and restarts the stream; a request in flight at redirect time
//   is drained and its data dropped.
//
// Configuration
//   IFU_BYPASS_EN  when defined, an ack arriving with the buffer empty is
//                  presented to decode in the same cycle and only buffered
//                  if decode does not take it.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o       fetch request strobe and address
//   imem_ack_i / imem_data_i       fetch response
//   redirect_i / redirect_addr_i   restart fetch stream at a new address
//   instr_valid_o / instr_ready_i  decode handshake
//   instr_o / instr_addr_o         instruction at buffer head and its address
// ----------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [INSTR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               imem_req_o,
    output logic [INSTR_W-1:0] imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               redirect_i,
    input  logic [INSTR_W-1:0] redirect_addr_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] instr_addr_o
);

    localparam int              CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

    ifu_state_t         state;
    logic [INSTR_W-1:0] pc;
    logic               ack_live;
    logic               ack_keep;
    logic               req;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    fetch_entry_t       head;
    fetch_entry_t       ack_entry;

    // Acks only matter while a live request is outstanding; in FETCH they
    // are stale (e.g. from before a reset) and in DISCARD they are flushed.
    assign ack_live = imem_ack_i && (state == WAIT);
    assign ack_keep = ack_live && !redirect_i;

    // Occupancy counts the outstanding request so the buffer can never
    // overflow. Issue is allowed in FETCH, or in WAIT on the acking cycle.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(state == WAIT);
    assign req       = ((state == FETCH) || ack_live) && !redirect_i
                       && (occupancy < DEPTH_LIMIT);

    assign imem_req_o  = req && !reset_i;
    assign imem_addr_o = pc;

    // The PC already advanced past the outstanding request, and any redirect
    // since issue would have left WAIT, so the request address is pc - 4.
    assign ack_entry.addr  = pc - PC_INC;
    assign ack_entry.instr = imem_data_i;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        instr_valid_o = !fifo_empty;
        instr_o       = '0;
        instr_addr_o  = '0;
        fifo_push     = ack_keep && !fifo_full;
        fifo_pop      = !fifo_empty && instr_ready_i;
        if (!fifo_empty) begin
            instr_o      = head.instr;
            instr_addr_o = head.addr;
        end
`ifdef IFU_BYPASS_EN
        else if (ack_keep) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_data_i;
            instr_addr_o  = ack_entry.addr;
            fifo_push     = !instr_ready_i;
        end
`endif
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush      (redirect_i),
        .push       (fifo_push),
        .push_entry (ack_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= FETCH;
            pc    <= RESET_ADDR;
        end else begin
            if (redirect_i) pc <= redirect_addr_i & ALIGN_MASK;
            else if (req)   pc <= pc + PC_INC;

            case (state)
                FETCH: begin
                    if (req) state <= WAIT;
                end
                WAIT: begin
                    if (redirect_i)      state <= imem_ack_i ? FETCH : DISCARD;
                    else if (imem_ack_i) state <= req ? WAIT : FETCH;
                end
                DISCARD: begin
                    if (imem_ack_i) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit (default build, FIFO_DEPTH=4,
//   RESET_ADDR=0). A small memory model answers each request after a
//   programmable latency with mem_word(addr); decode transfers are logged.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } xfer_t;

    logic        clk;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;

    instruction_fetch_unit #(
        .FIFO_DEPTH (4),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_addr_o    (instr_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model state
    int          lat      = 1;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = '0;
    int          rem      = 0;

    // per-cycle samples
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_iaddr;
    xfer_t       delivered[$];
    int          req_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] dlv_addr(input int i);
        return (i < delivered.size()) ? delivered[i].addr : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dlv_instr(input int i);
        return (i < delivered.size()) ? delivered[i].instr : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        imem_ack_i  = pend && (rem == 0);
        imem_data_i = imem_ack_i ? mem_word(pend_addr) : 32'h0;
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = instr_valid_o;
        s_instr = instr_o;
        s_iaddr = instr_addr_o;
        if (s_req) req_cnt++;
        if (s_valid && instr_ready_i) delivered.push_back('{addr: s_iaddr, instr: s_instr});
        if (imem_ack_i) pend = 1'b0;
        else if (pend)  rem--;
        if (s_req) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            rem       = lat - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int latency, input logic ready);
        reset_i       = 1'b1;
        redirect_i    = 1'b0;
        instr_ready_i = ready;
        step();
        step();
        pend      = 1'b0;
        lat       = latency;
        reset_i   = 1'b0;
        delivered.delete();
        req_cnt   = 0;
    endtask

    initial begin
        reset_i         = 1'b1;
        imem_ack_i      = 1'b0;
        imem_data_i     = '0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        instr_ready_i   = 1'b0;
        req_cnt         = 0;

        // ---- reset state ----
        @(negedge clk);
        #1;
        check("rst_req",   32'(imem_req_o),    32'd0);
        check("rst_addr",  imem_addr_o,        32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o,            32'h0);
        check("rst_iaddr", instr_addr_o,       32'h0);
        @(negedge clk);

        // ---- back-to-back fetch, 1-cycle memory, ready=1 ----
        do_reset(1, 1'b1);
        step();
        check("b2b_c0_req",  32'(s_req), 32'd1);
        check("b2b_c0_addr", s_addr,     32'h0);
        step();
        check("b2b_c1_addr",  s_addr,       32'h4);
        check("b2b_c1_valid", 32'(s_valid), 32'd0);
        step();
        check("b2b_c2_addr",  s_addr,       32'h8);
        check("b2b_c2_valid", 32'(s_valid), 32'd1);
        check("b2b_c2_iaddr", s_iaddr,      32'h0);
        check("b2b_c2_instr", s_instr,      mem_word(32'h0));
        step();
        check("b2b_c3_iaddr", s_iaddr,      32'h4);

        // ---- decode stalled: buffer fills, requests stop ----
        do_reset(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) check("stall_hold_c4", s_instr, mem_word(32'h0));
        end
        check("stall_req_cnt",  32'(req_cnt), 32'd4);
        check("stall_last_req", 32'(s_req),   32'd0);
        check("stall_instr",    s_instr,      mem_word(32'h0));
        check("stall_iaddr",    s_iaddr,      32'h0);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("drain_0",     dlv_addr(0),  32'h0);
        check("drain_3",     dlv_addr(3),  32'hC);
        check("drain_4",     dlv_addr(4),  32'h10);
        check("drain_4_dat", dlv_instr(4), mem_word(32'h10));

        // ---- redirect while WAIT (2-cycle memory) ----
        do_reset(2, 1'b1);
        step();
        check("rdw_c0_req", 32'(s_req), 32'd1);
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h103;
        step();
        check("rdw_c1_req", 32'(s_req), 32'd0);
        redirect_i = 1'b0;
        step();
        check("rdw_discard_req", 32'(s_req), 32'd0);
        step();
        check("rdw_tgt_req",  32'(s_req), 32'd1);
        check("rdw_tgt_addr", s_addr,     32'h100);
        for (int i = 0; i < 6; i++) step();
        check("rdw_first_addr",  dlv_addr(0),  32'h100);
        check("rdw_first_instr", dlv_instr(0), mem_word(32'h100));

        // ---- redirect in the same cycle as ack ----
        do_reset(1, 1'b1);
        step();
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h200;
        step();
        check("rda_c1_req", 32'(s_req), 32'd0);
        redirect_i = 1'b0;
        step();
        check("rda_tgt_req",   32'(s_req),   32'd1);
        check("rda_tgt_addr",  s_addr,       32'h200);
        check("rda_tgt_valid", 32'(s_valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("rda_first_addr", dlv_addr(0), 32'h200);

        // ---- redirect together with a transfer from a full buffer ----
        do_reset(1, 1'b0);
        for (int i = 0; i < 6; i++) step();
        instr_ready_i   = 1'b1;
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h300;
        step();
        check("rdx_valid", 32'(s_valid), 32'd1);
        check("rdx_iaddr", dlv_addr(0),  32'h0);
        redirect_i = 1'b0;
        step();
        check("rdx_next_valid", 32'(s_valid), 32'd0);
        check("rdx_next_addr",  s_addr,       32'h300);
        check("rdx_delivered",  32'(delivered.size()), 32'd1);

        // ---- PC wraps from 0xFFFFFFFC to 0 ----
        do_reset(1, 1'b1);
        step();
        redirect_i      = 1'b1;
        redirect_addr_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        check("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_req",     32'(s_req), 32'd1);
        check("wrap_addr_lo", s_addr,     32'h0);
        for (int i = 0; i < 3; i++) step();
        check("wrap_dlv0", dlv_addr(0), 32'hFFFF_FFFC);
        check("wrap_dlv1", dlv_addr(1), 32'h0);

        // ---- reset mid-WAIT with 3-cycle memory, stale ack afterwards ----
        do_reset(3, 1'b1);
        step();
        step();
        check("mid_wait_pc", s_addr, 32'h4);
        reset_i = 1'b1;
        #1;
        check("mid_rst_req",   32'(imem_req_o),    32'd0);
        check("mid_rst_addr",  imem_addr_o,        32'h0);
        check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        step();
        reset_i = 1'b0;
        step();
        check("mid_stale_ack",  32'(imem_ack_i), 32'd1);
        check("mid_restart_req",  32'(s_req),    32'd1);
        check("mid_restart_addr", s_addr,        32'h0);
        for (int i = 0; i < 5; i++) step();
        check("mid_dlv_cnt",   32'(delivered.size()), 32'd1);
        check("mid_dlv_addr",  dlv_addr(0),  32'h0);
        check("mid_dlv_instr", dlv_instr(0), mem_word(32'h0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
